cache_axi_rd_arbiter: RTL and testbench
=======================================

// Module: cache_axi_rd_arbiter
// PURPOSE
//  Shares the single AXI master port between the instruction cache (port I) and data cache (port D).
//  Arbitrates AR requests, routes R beats back by rid, and passes D's AW/W/B through unchanged.
//  Sits between the two caches and the SoC AXI interconnect.
//  Allows one outstanding burst per requester, so at most two bursts are outstanding on the bus.
// PARAMETERS
//  I_ID       4'd3  arid used by Icache; R beats with this rid route to port I
//  D_ID       4'd1  arid used by Dcache; R beats with this rid route to port D
//  ADDR_W     32    address width
// PORTS
//  clk        in   1   clock
//  resetn     in   1   synchronous active-low reset
//  i_ar{id,addr,len,size,burst,valid}  in  4/ADDR_W/8/3/2/1  Icache AR request
//  i_arready  out  1   AR accepted for I
//  i_r{id,data,resp,last,valid}  out  4/32/2/1/1  R beats routed to I
//  i_rready   in   1   I accepts a beat
//  d_ar*/d_arready/d_r*/d_rready  -    same as I, for Dcache
//  d_aw*,d_w*,d_b*    -    Dcache write channels, wired straight to m_aw*/m_w*/m_b*
//  m_ar{id,addr,len,size,burst,valid}  out  -  to interconnect; arlock/arcache/arprot tied 0
//  m_arready  in   1
//  m_r{id,data,resp,last,valid}  in  -  ;  m_rready  out  1
// BEHAVIOUR
//  AR FSM states:
//   - AR_IDLE: transitions only when a requester is eligible.
//     Eligible means {x}_arvalid && !pend_x.
//     Winner is chosen by the policy below; grant_x is latched; next state is AR_HOLD.
//   - AR_HOLD: m_ar* = the latched winner's fields; m_arvalid = 1.
//     On m_arready: set pend_winner, return to AR_IDLE.
//  Grant is stable while in AR_HOLD; a requester dropping arvalid there is a protocol error (not handled).
//  {x}_arready = (state==AR_HOLD) && grant_x && m_arready. Zero-cycle bypass is not allowed: min AR latency is 1 cycle.
//  pend_x clears on an R handshake with rlast and rid==X_ID.
//  A set clear and a set on the same cycle cannot occur for one port, because a port is not eligible while pending.
//  R routing is combinational:
//   - i_rvalid = m_rvalid && rid==I_ID; d_rvalid = m_rvalid && rid==D_ID.
//   - m_rready = i_rready if rid==I_ID, d_rready if rid==D_ID, else 1 (beats with an unknown rid are drained).
//   - rdata/rresp/rlast/rid are broadcast to both ports.
//  Reset values:
//   - state=AR_IDLE, pend_i=pend_d=0, grant=D, rr_last=I.
//   - All valid/ready outputs 0 except m_rready, which follows the R routing rules above.
//  Policy without ARB_RR_EN: fixed priority, D over I.
//  Write path: pure wires, no state. A D write may overlap any read.
//  Reset mid-burst: all state clears. The interconnect is reset together with the caches, so in-flight beats are not tracked.
// CONFIGURATION
//  ARB_RR_EN defined:
//   - Round-robin arbitration. rr_last records the last granted port.
//   - On a tie, the port other than rr_last wins. rr_last updates on the AR handshake.
//  ARB_RR_EN undefined: D always wins a tie, and rr_last is not instantiated.
// STRUCTURE
//  Shared package/header cache.h holds:
//   - ICACHE_ARID, DCACHE_ARID
//   - AR_IDLE/AR_HOLD encodings
//   - the AXI field widths
//  One sub-module, axi_ar_mux: 2:1 AR field mux driven by the grant.
//  The FSM, pending bits and R demux stay at top level.
// TESTING
//  1. I alone: i_araddr=0x1fc00000, len=7, arready after 2 cycles.
//     -> m_araddr=0x1fc00000, m_arid=3, i_arready pulses once.
//     -> 8 beats with rid=3 reach I only; pend_i clears after the rlast beat.
//  2. I and D raise arvalid in the same cycle (fixed priority).
//     -> D granted first (m_arid=1), then I on the next AR_IDLE.
//     -> Both bursts are outstanding; interleaved beats rid 1/3 route correctly.
//  3. ARB_RR_EN: three back-to-back ties -> grant order D,I,D.
//  4. Backpressure: i_rready=0 while a rid=3 beat is valid.
//     -> m_rready=0 and the beat is held.
//     -> A rid=1 beat on a later cycle is accepted by D independently.
//  5. D issues a second AR while pend_d=1.
//     -> d_arready stays 0 until D's rlast handshake, then the AR is granted.
//  6. resetn=0 for 1 cycle mid-burst.
//     -> state=AR_IDLE, pend_*=0, m_arvalid=0 on the next cycle.

Source files
------------

// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared definitions for the I/D cache AXI read arbiter: cache ARIDs, AR FSM encodings, AXI field widths.
package cache_axi_rd_arbiter_pkg;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int RDATA_W = 32;
    localparam int WDATA_W = 32;
    localparam int WSTRB_W = WDATA_W / 8;

    localparam logic [ID_W-1:0] ICACHE_ARID = 4'd3;
    localparam logic [ID_W-1:0] DCACHE_ARID = 4'd1;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_HOLD = 1'b1
    } ar_state_e;

    typedef enum logic {
        GNT_D = 1'b0,
        GNT_I = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_ctl_t;
endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// AXI port bundle (AR/R plus AW/W/B) used for both cache ports and the shared master port.
interface cache_axi_rd_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    import cache_axi_rd_arbiter_pkg::*;

    logic [ID_W-1:0]    arid;
    logic [ADDR_W-1:0]  araddr;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic               arlock;
    logic [3:0]         arcache;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               arready;

    logic [ID_W-1:0]    rid;
    logic [RDATA_W-1:0] rdata;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    logic [ID_W-1:0]    awid;
    logic [ADDR_W-1:0]  awaddr;
    logic [LEN_W-1:0]   awlen;
    logic [SIZE_W-1:0]  awsize;
    logic [BURST_W-1:0] awburst;
    logic               awvalid;
    logic               awready;

    logic [WDATA_W-1:0] wdata;
    logic [WSTRB_W-1:0] wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;

    logic [ID_W-1:0]    bid;
    logic [RESP_W-1:0]  bresp;
    logic               bvalid;
    logic               bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_rd_arbiter_axi_ar_mux.sv
// axi_ar_mux: 2:1 selection of the AR request fields between Dcache and Icache, steered by the grant.
module cache_axi_rd_arbiter_axi_ar_mux
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  grant_e            i_sel,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  ar_ctl_t           i_d_ctl,
    input  logic [ADDR_W-1:0] i_i_addr,
    input  ar_ctl_t           i_i_ctl,
    output logic [ADDR_W-1:0] o_addr,
    output ar_ctl_t           o_ctl
);
    assign o_addr = (i_sel == GNT_I) ? i_i_addr : i_d_addr;
    assign o_ctl  = (i_sel == GNT_I) ? i_i_ctl  : i_d_ctl;
endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI master between Icache and Dcache reads; D writes pass straight through.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with D over I.
module cache_axi_rd_arbiter
    import cache_axi_rd_arbiter_pkg::*;
#(
    parameter logic [ID_W-1:0] I_ID   = ICACHE_ARID,
    parameter logic [ID_W-1:0] D_ID   = DCACHE_ARID,
    parameter int              ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    cache_axi_rd_arbiter_if.slave  icache,
    cache_axi_rd_arbiter_if.slave  dcache,
    cache_axi_rd_arbiter_if.master maxi
);
    ar_state_e r_state, w_state_nxt;
    grant_e    r_grant, w_grant_nxt, w_winner;
    logic      r_pend_i, r_pend_d;
    logic      w_elig_i, w_elig_d, w_ar_hs, w_rid_i, w_rid_d, w_clr_i, w_clr_d;
    ar_ctl_t   w_i_ctl, w_d_ctl, w_m_ctl;
`ifdef ARB_RR_EN
    grant_e    r_rr_last;
`endif

    // A port with a burst in flight may not issue another AR until its rlast returns.
    assign w_elig_i = icache.arvalid && !r_pend_i;
    assign w_elig_d = dcache.arvalid && !r_pend_d;
    assign w_ar_hs  = (r_state == AR_HOLD) && maxi.arready;
    assign w_rid_i  = (maxi.rid == I_ID);
    assign w_rid_d  = (maxi.rid == D_ID);
    assign w_clr_i  = maxi.rvalid && maxi.rready && maxi.rlast && w_rid_i;
    assign w_clr_d  = maxi.rvalid && maxi.rready && maxi.rlast && w_rid_d;

    always_comb begin
        w_winner = GNT_D;
`ifdef ARB_RR_EN
        if (w_elig_i && w_elig_d)
            w_winner = (r_rr_last == GNT_D) ? GNT_I : GNT_D;
        else if (w_elig_i)
            w_winner = GNT_I;
`else
        if (w_elig_i && !w_elig_d)
            w_winner = GNT_I;
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= AR_IDLE;
            r_grant  <= GNT_D;
            r_pend_i <= 1'b0;
            r_pend_d <= 1'b0;
`ifdef ARB_RR_EN
            r_rr_last <= GNT_I;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_ar_hs && r_grant == GNT_I) r_pend_i <= 1'b1;
            else if (w_clr_i)                r_pend_i <= 1'b0;
            if (w_ar_hs && r_grant == GNT_D) r_pend_d <= 1'b1;
            else if (w_clr_d)                r_pend_d <= 1'b0;
`ifdef ARB_RR_EN
            if (w_ar_hs) r_rr_last <= r_grant;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            AR_IDLE: if (w_elig_i || w_elig_d) begin
                w_state_nxt = AR_HOLD;
                w_grant_nxt = w_winner;
            end
            AR_HOLD: if (maxi.arready) w_state_nxt = AR_IDLE;
            default: w_state_nxt = AR_IDLE;
        endcase
    end

    always_comb begin
        maxi.arvalid   = (r_state == AR_HOLD);
        icache.arready = w_ar_hs && (r_grant == GNT_I);
        dcache.arready = w_ar_hs && (r_grant == GNT_D);
    end

    assign w_i_ctl = '{id: icache.arid, len: icache.arlen, size: icache.arsize, burst: icache.arburst};
    assign w_d_ctl = '{id: dcache.arid, len: dcache.arlen, size: dcache.arsize, burst: dcache.arburst};

    cache_axi_rd_arbiter_axi_ar_mux #(.ADDR_W(ADDR_W)) u_ar_mux (
        .i_sel    (r_grant),
        .i_d_addr (dcache.araddr),
        .i_d_ctl  (w_d_ctl),
        .i_i_addr (icache.araddr),
        .i_i_ctl  (w_i_ctl),
        .o_addr   (maxi.araddr),
        .o_ctl    (w_m_ctl)
    );

    assign maxi.arid    = w_m_ctl.id;
    assign maxi.arlen   = w_m_ctl.len;
    assign maxi.arsize  = w_m_ctl.size;
    assign maxi.arburst = w_m_ctl.burst;
    assign maxi.arlock  = 1'b0;
    assign maxi.arcache = 4'd0;
    assign maxi.arprot  = 3'd0;

    // R demux by rid; beats carrying an unknown rid are drained so they cannot stall the bus.
    assign icache.rvalid = maxi.rvalid && w_rid_i;
    assign dcache.rvalid = maxi.rvalid && w_rid_d;
    assign maxi.rready   = w_rid_i ? icache.rready : (w_rid_d ? dcache.rready : 1'b1);
    assign icache.rid    = maxi.rid;
    assign icache.rdata  = maxi.rdata;
    assign icache.rresp  = maxi.rresp;
    assign icache.rlast  = maxi.rlast;
    assign dcache.rid    = maxi.rid;
    assign dcache.rdata  = maxi.rdata;
    assign dcache.rresp  = maxi.rresp;
    assign dcache.rlast  = maxi.rlast;

    assign maxi.awid     = dcache.awid;
    assign maxi.awaddr   = dcache.awaddr;
    assign maxi.awlen    = dcache.awlen;
    assign maxi.awsize   = dcache.awsize;
    assign maxi.awburst  = dcache.awburst;
    assign maxi.awvalid  = dcache.awvalid;
    assign dcache.awready = maxi.awready;
    assign maxi.wdata    = dcache.wdata;
    assign maxi.wstrb    = dcache.wstrb;
    assign maxi.wlast    = dcache.wlast;
    assign maxi.wvalid   = dcache.wvalid;
    assign dcache.wready = maxi.wready;
    assign dcache.bid    = maxi.bid;
    assign dcache.bresp  = maxi.bresp;
    assign dcache.bvalid = maxi.bvalid;
    assign maxi.bready   = dcache.bready;

    // Icache is read-only: its write channels are parked.
    assign icache.awready = 1'b0;
    assign icache.wready  = 1'b0;
    assign icache.bid     = '0;
    assign icache.bresp   = '0;
    assign icache.bvalid  = 1'b0;
endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: reset, single-port burst, ties, backpressure, pending block, mid-burst reset, write passthrough.
module tb_cache_axi_rd_arbiter;
    import cache_axi_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter_if #(.ADDR_W(32)) ic_if ();
    cache_axi_rd_arbiter_if #(.ADDR_W(32)) dc_if ();
    cache_axi_rd_arbiter_if #(.ADDR_W(32)) m_if ();

    cache_axi_rd_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .icache (ic_if),
        .dcache (dc_if),
        .maxi   (m_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ic_if.arid = ICACHE_ARID; ic_if.araddr = '0; ic_if.arlen = '0; ic_if.arsize = 3'd2;
        ic_if.arburst = 2'd1; ic_if.arvalid = 1'b0; ic_if.arlock = 1'b0; ic_if.arcache = '0;
        ic_if.arprot = '0; ic_if.rready = 1'b1; ic_if.awid = '0; ic_if.awaddr = '0;
        ic_if.awlen = '0; ic_if.awsize = '0; ic_if.awburst = '0; ic_if.awvalid = 1'b0;
        ic_if.wdata = '0; ic_if.wstrb = '0; ic_if.wlast = 1'b0; ic_if.wvalid = 1'b0; ic_if.bready = 1'b0;
        dc_if.arid = DCACHE_ARID; dc_if.araddr = '0; dc_if.arlen = '0; dc_if.arsize = 3'd2;
        dc_if.arburst = 2'd1; dc_if.arvalid = 1'b0; dc_if.arlock = 1'b0; dc_if.arcache = '0;
        dc_if.arprot = '0; dc_if.rready = 1'b1; dc_if.awid = '0; dc_if.awaddr = '0;
        dc_if.awlen = '0; dc_if.awsize = '0; dc_if.awburst = '0; dc_if.awvalid = 1'b0;
        dc_if.wdata = '0; dc_if.wstrb = '0; dc_if.wlast = 1'b0; dc_if.wvalid = 1'b0; dc_if.bready = 1'b0;
        m_if.arready = 1'b0; m_if.rid = 4'd0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
        m_if.rvalid = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bid = '0;
        m_if.bresp = '0; m_if.bvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({m_if.arvalid, ic_if.arready, dc_if.arready, ic_if.rvalid, dc_if.rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b required 00000",
                     {m_if.arvalid, ic_if.arready, dc_if.arready, ic_if.rvalid, dc_if.rvalid});
        end
        checks++;
        if (m_if.rready !== 1'b1) begin
            errors++; $display("FAIL reset_rready_unknown_rid: got %b required 1", m_if.rready);
        end
        checks++;
        if (dut.r_pend_i !== 1'b0 || dut.r_pend_d !== 1'b0 || dut.r_state !== AR_IDLE) begin
            errors++; $display("FAIL reset_state: got pend_i=%b pend_d=%b state=%0d required 0 0 0",
                               dut.r_pend_i, dut.r_pend_d, dut.r_state);
        end
        step();
        resetn = 1'b1;
    endtask

    task automatic test_i_alone();
        int pulses = 0;
        ic_if.araddr = 32'h1fc0_0000; ic_if.arlen = 8'd7; ic_if.arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (m_if.arvalid !== 1'b0 || ic_if.arready !== 1'b0) begin
            errors++; $display("FAIL i_alone_no_bypass: got arvalid=%b arready=%b required 0 0",
                               m_if.arvalid, ic_if.arready);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            m_if.arready = (k == 2);
            @(negedge clk);
            if (ic_if.arready === 1'b1) pulses++;
            if (k == 0) begin
                checks++;
                if (m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h1fc0_0000 || m_if.arid !== 4'd3 || m_if.arlen !== 8'd7) begin
                    errors++; $display("FAIL i_alone_ar: got v=%b addr=%h id=%0d len=%0d required 1 1fc00000 3 7",
                                       m_if.arvalid, m_if.araddr, m_if.arid, m_if.arlen);
                end
            end
            step();
        end
        ic_if.arvalid = 1'b0; m_if.arready = 1'b0;
        checks++;
        if (pulses != 1 || dut.r_pend_i !== 1'b1) begin
            errors++; $display("FAIL i_alone_arready_pulse: got pulses=%0d pend_i=%b required 1 1", pulses, dut.r_pend_i);
        end
        for (int b = 0; b < 8; b++) begin
            m_if.rvalid = 1'b1; m_if.rid = 4'd3; m_if.rdata = 32'h100 + b; m_if.rlast = (b == 7);
            @(negedge clk);
            checks++;
            if (ic_if.rvalid !== 1'b1 || dc_if.rvalid !== 1'b0 || ic_if.rdata !== 32'h100 + b || m_if.rready !== 1'b1) begin
                errors++; $display("FAIL i_alone_beat%0d: got iv=%b dv=%b data=%h rready=%b required 1 0 %h 1",
                                   b, ic_if.rvalid, dc_if.rvalid, ic_if.rdata, m_if.rready, 32'h100 + b);
            end
            step();
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        checks++;
        if (dut.r_pend_i !== 1'b0) begin
            errors++; $display("FAIL i_alone_pend_clear: got %b required 0", dut.r_pend_i);
        end
    endtask

    task automatic test_tie_fixed_then_interleave();
        logic [3:0] rids  [6];
        logic       lasts [6];
        rids  = '{4'd1, 4'd3, 4'd1, 4'd1, 4'd3, 4'd1};
        lasts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        dc_if.araddr = 32'h8000_0000; dc_if.arlen = 8'd3; dc_if.arvalid = 1'b1;
        ic_if.araddr = 32'h1fc0_0040; ic_if.arlen = 8'd1; ic_if.arvalid = 1'b1;
        m_if.arready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (m_if.arid !== 4'd1 || dc_if.arready !== 1'b1 || ic_if.arready !== 1'b0 || m_if.araddr !== 32'h8000_0000) begin
            errors++; $display("FAIL tie_first_grant: got id=%0d d_rdy=%b i_rdy=%b addr=%h required 1 1 0 80000000",
                               m_if.arid, dc_if.arready, ic_if.arready, m_if.araddr);
        end
        step();
        dc_if.arvalid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (m_if.arid !== 4'd3 || ic_if.arready !== 1'b1 || m_if.araddr !== 32'h1fc0_0040) begin
            errors++; $display("FAIL tie_second_grant: got id=%0d i_rdy=%b addr=%h required 3 1 1fc00040",
                               m_if.arid, ic_if.arready, m_if.araddr);
        end
        step();
        ic_if.arvalid = 1'b0; m_if.arready = 1'b0;
        checks++;
        if (dut.r_pend_i !== 1'b1 || dut.r_pend_d !== 1'b1) begin
            errors++; $display("FAIL both_outstanding: got pend_i=%b pend_d=%b required 1 1", dut.r_pend_i, dut.r_pend_d);
        end
        for (int b = 0; b < 6; b++) begin
            m_if.rvalid = 1'b1; m_if.rid = rids[b]; m_if.rlast = lasts[b]; m_if.rdata = 32'hA0 + b;
            @(negedge clk);
            checks++;
            if (ic_if.rvalid !== (rids[b] == 4'd3) || dc_if.rvalid !== (rids[b] == 4'd1) || m_if.rready !== 1'b1) begin
                errors++; $display("FAIL interleave_beat%0d: got iv=%b dv=%b rready=%b required %b %b 1",
                                   b, ic_if.rvalid, dc_if.rvalid, m_if.rready, rids[b] == 4'd3, rids[b] == 4'd1);
            end
            step();
        end
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        checks++;
        if (dut.r_pend_i !== 1'b0 || dut.r_pend_d !== 1'b0) begin
            errors++; $display("FAIL interleave_pend_clear: got pend_i=%b pend_d=%b required 0 0", dut.r_pend_i, dut.r_pend_d);
        end
    endtask

    task automatic test_tie_order();
        logic [3:0] exp_id [3];
`ifdef ARB_RR_EN
        exp_id = '{4'd1, 4'd3, 4'd1};
`else
        exp_id = '{4'd1, 4'd1, 4'd1};
`endif
        do_reset();
        for (int r = 0; r < 3; r++) begin
            ic_if.arvalid = 1'b1; dc_if.arvalid = 1'b1; m_if.arready = 1'b1;
            step();
            @(negedge clk);
            checks++;
            if (m_if.arid !== exp_id[r]) begin
                errors++; $display("FAIL tie_order_round%0d: got arid=%0d required %0d", r, m_if.arid, exp_id[r]);
            end
            step();
            ic_if.arvalid = 1'b0; dc_if.arvalid = 1'b0; m_if.arready = 1'b0;
            m_if.rvalid = 1'b1; m_if.rid = exp_id[r]; m_if.rlast = 1'b1;
            step();
            m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        ic_if.rready = 1'b0; dc_if.rready = 1'b1;
        m_if.rvalid = 1'b1; m_if.rid = 4'd3; m_if.rlast = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (m_if.rready !== 1'b0 || ic_if.rvalid !== 1'b1 || dc_if.rvalid !== 1'b0) begin
                errors++; $display("FAIL backpressure_hold%0d: got rready=%b iv=%b dv=%b required 0 1 0",
                                   k, m_if.rready, ic_if.rvalid, dc_if.rvalid);
            end
            step();
        end
        m_if.rid = 4'd1;
        @(negedge clk);
        checks++;
        if (m_if.rready !== 1'b1 || dc_if.rvalid !== 1'b1 || ic_if.rvalid !== 1'b0) begin
            errors++; $display("FAIL backpressure_d_accept: got rready=%b dv=%b iv=%b required 1 1 0",
                               m_if.rready, dc_if.rvalid, ic_if.rvalid);
        end
        step();
        m_if.rid = 4'd7; dc_if.rready = 1'b0;
        @(negedge clk);
        checks++;
        if (m_if.rready !== 1'b1 || dc_if.rvalid !== 1'b0 || ic_if.rvalid !== 1'b0) begin
            errors++; $display("FAIL unknown_rid_drain: got rready=%b dv=%b iv=%b required 1 0 0",
                               m_if.rready, dc_if.rvalid, ic_if.rvalid);
        end
        step();
        m_if.rvalid = 1'b0; ic_if.rready = 1'b1; dc_if.rready = 1'b1;
    endtask

    task automatic test_pending_block();
        int early = 0;
        dc_if.araddr = 32'h0000_1000; dc_if.arlen = 8'd0; dc_if.arvalid = 1'b1; m_if.arready = 1'b1;
        step();
        step();
        dc_if.araddr = 32'h0000_2000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dc_if.arready !== 1'b0 || m_if.arvalid !== 1'b0) early++;
            step();
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL pend_block: got %0d cycles with arvalid/arready while pending required 0", early);
        end
        m_if.rvalid = 1'b1; m_if.rid = 4'd1; m_if.rlast = 1'b1;
        step();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (m_if.arvalid !== 1'b1 || dc_if.arready !== 1'b1 || m_if.araddr !== 32'h0000_2000) begin
            errors++; $display("FAIL pend_release_grant: got v=%b d_rdy=%b addr=%h required 1 1 00002000",
                               m_if.arvalid, dc_if.arready, m_if.araddr);
        end
        step();
        dc_if.arvalid = 1'b0; m_if.arready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rid = 4'd1; m_if.rlast = 1'b1;
        step();
        m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        ic_if.araddr = 32'h1fc0_0100; ic_if.arlen = 8'd3; ic_if.arvalid = 1'b1; m_if.arready = 1'b1;
        step();
        step();
        ic_if.arvalid = 1'b0; m_if.arready = 1'b0; dc_if.arvalid = 1'b1;
        step();
        m_if.rvalid = 1'b1; m_if.rid = 4'd3; m_if.rlast = 1'b0;
        @(negedge clk);
        checks++;
        if (m_if.arvalid !== 1'b1 || dut.r_pend_i !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: got arvalid=%b pend_i=%b required 1 1", m_if.arvalid, dut.r_pend_i);
        end
        resetn = 1'b0;
        step();
        resetn = 1'b1; dc_if.arvalid = 1'b0; m_if.rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (m_if.arvalid !== 1'b0 || dut.r_pend_i !== 1'b0 || dut.r_pend_d !== 1'b0 || dut.r_state !== AR_IDLE) begin
            errors++; $display("FAIL reset_mid_burst: got arvalid=%b pend_i=%b pend_d=%b state=%0d required 0 0 0 0",
                               m_if.arvalid, dut.r_pend_i, dut.r_pend_d, dut.r_state);
        end
        step();
    endtask

    task automatic test_write_passthrough();
        dc_if.awaddr = 32'hDEAD_0040; dc_if.awvalid = 1'b1; dc_if.wdata = 32'h1234_5678; dc_if.wvalid = 1'b1;
        dc_if.bready = 1'b1; m_if.awready = 1'b1; m_if.bvalid = 1'b1; m_if.bresp = 2'd2;
        @(negedge clk);
        checks++;
        if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'hDEAD_0040 || m_if.wdata !== 32'h1234_5678 ||
            dc_if.awready !== 1'b1 || dc_if.bvalid !== 1'b1 || dc_if.bresp !== 2'd2 || m_if.bready !== 1'b1) begin
            errors++; $display("FAIL write_passthrough: got awv=%b awaddr=%h wdata=%h awrdy=%b bv=%b bresp=%0d bready=%b",
                               m_if.awvalid, m_if.awaddr, m_if.wdata, dc_if.awready, dc_if.bvalid, dc_if.bresp, m_if.bready);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_i_alone();
        test_tie_fixed_then_interleave();
        test_tie_order();
        test_backpressure();
        test_pending_block();
        test_reset_mid_burst();
        test_write_passthrough();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
